crc_serial: RTL and testbench
=============================

Name: crc_serial

Overview:
- Bit-serial CRC generator that consumes the single-bit XOR feedback stream; it is the stateful stage downstream of the team's two-input XOR cell.
- Each accepted bit is combined with the register MSB, and the feedback conditionally XORs the polynomial into the shifted register.
- A start/valid/done handshake frames a fixed-length message.
- Used as the checksum stage in the CA2 datapath. The feedback path is built from instances of the existing XOR cell.

Parameters:
- WIDTH, 8, CRC register width in bits.
- POLY, 8'h07, generator polynomial without the implicit x^WIDTH term.
- INIT, 8'h00, register value loaded on start.
- MSG_LEN, 8, number of message bits per frame (1..255).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame start request; honoured only in IDLE or DONE.
- bit_in  input  1  message bit, MSB-first.
- bit_valid  input  1  bit_in is presented this cycle.
- ready  output  1  high in SHIFT; bit_in is accepted when bit_valid && ready.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse when the frame completes.
- crc_out  output  WIDTH  current CRC register value; stable from done until the next start.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, crc=0, bit counter=0; ready=0, busy=0, done=0, crc_out=0. Reset overrides every other input, including mid-frame; a partial CRC is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 -> SHIFT. crc<=INIT, cnt<=MSG_LEN. No bit is accepted in the start cycle.
- SHIFT, on an accept (bit_valid=1):
  - fb = crc[WIDTH-1] ^ bit_in
  - crc <= {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)
  - cnt <= cnt-1
- SHIFT, bit_valid=0: crc and cnt hold; gaps of any length are allowed.
- SHIFT, accept with cnt==1 -> DONE. done=1 in the first DONE cycle only (registered, one cycle after the last accepted bit).
- DONE: crc_out holds. start=1 -> SHIFT with re-init (back-to-back frames); otherwise stay in DONE with done=0.
- start while in SHIFT: ignored; the frame continues.
- bit_valid outside SHIFT: ignored and has no effect on crc.
- crc_out is the direct register value, including intermediate values during SHIFT. It reads 0 after reset until the first start.
- Latency: start edge -> first accept possible on the next edge. Minimum frame time is MSG_LEN+1 cycles from start to done.
- Counter width: 8 bits. Arithmetic is mod 2 only; no carries.

Decomposition:
- Shared package crc_pkg holds:
  - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - default POLY/INIT constants
  - CRC8_WIDTH=8
- One sub-module, crc_step: purely combinational next-state function (crc, bit_in, POLY) -> crc_next.
  - Built from Xor cell instances: one for the feedback, one per set POLY bit.
  - Reusable by a later parallel/unrolled CRC.
- Top module holds the FSM, the counter and the register.

Test Plan:
- rst=1 for 2 cycles with start/bit_valid toggling -> ready=busy=done=0, crc_out=8'h00 throughout.
- start, then byte 8'h01 MSB-first, bit_valid continuous -> done pulses exactly one cycle, 9 edges after the start edge; crc_out=8'h07.
- start, byte 8'hFF with bit_valid deasserted for 3 cycles after bits 2 and 5 -> crc_out=8'hF3; done delayed by 6 cycles; cnt unchanged during gaps.
- start, byte 8'h00 -> crc_out=8'h00, done=1 once; a start pulse mid-frame is ignored (result still 8'h00, no early done).
- Frame 8'h01, then start in the done cycle, then frame 8'hFF -> crc_out reads 8'h07 then 8'hF3; second done follows 9 edges after the second start.
- rst asserted after 4 bits of 8'hFF -> IDLE, crc_out=8'h00; a following full 8'h01 frame -> 8'h07.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared constants for the bit-serial CRC stage: state encoding and CRC-8 defaults.
package crc_pkg;
    localparam int         CRC8_WIDTH = 8;
    localparam logic [7:0] CRC8_POLY  = 8'h07;
    localparam logic [7:0] CRC8_INIT  = 8'h00;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
endpackage

// File: rtl/crc_step.sv
// One-bit CRC next-state function (MSB-first), built from XOR cells.
// Only taps set in POLY get a cell, so the network is fixed at elaboration.
module crc_step
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC8_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = CRC8_POLY
) (
    input  logic [WIDTH-1:0] crc,
    input  logic             bit_in,
    output logic [WIDTH-1:0] crc_next
);
    logic             fb;
    logic [WIDTH-1:0] shifted;

    xor_cell u_fb (.a(crc[WIDTH-1]), .b(bit_in), .y(fb));

    assign shifted = {crc[WIDTH-2:0], 1'b0};

    for (genvar i = 0; i < WIDTH; i++) begin : g_tap
        if (POLY[i]) begin : g_xor
            xor_cell u_tap (.a(shifted[i]), .b(fb), .y(crc_next[i]));
        end else begin : g_pass
            assign crc_next[i] = shifted[i];
        end
    end
endmodule

// File: rtl/xor_cell.sv
// Two-input XOR cell; the building block of the CRC feedback network.
module xor_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/crc_serial.sv
// Bit-serial CRC generator with start/valid/done framing of a fixed-length message.
module crc_serial
    import crc_pkg::*;
#(
    parameter int               WIDTH   = CRC8_WIDTH,
    parameter logic [WIDTH-1:0] POLY    = CRC8_POLY,
    parameter logic [WIDTH-1:0] INIT    = CRC8_INIT,
    parameter int               MSG_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] crc_out
);
    logic [1:0]       state;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] crc;
    logic [WIDTH-1:0] crc_next;
    logic             done_q;

    crc_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
        .crc      (crc),
        .bit_in   (bit_in),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            crc    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= SHIFT;
                        crc   <= INIT;
                        cnt   <= 8'(MSG_LEN);
                    end
                end
                SHIFT: begin
                    // start is deliberately ignored here; the frame runs to completion
                    if (bit_valid) begin
                        crc <= crc_next;
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready   = (state == SHIFT);
    assign busy    = (state == SHIFT);
    assign done    = done_q;
    assign crc_out = crc;
endmodule

// File: tb/tb_crc_serial.sv
// Scoreboard bench for crc_serial: the driver queues expected CRC/latency per frame,
// the monitor checks them whenever done pulses.
module tb_crc_serial;
    logic       clk = 1'b0;
    logic       rst, start, bit_in, bit_valid;
    logic       ready, busy, done;
    logic [7:0] crc_out;

    typedef struct {
        logic [7:0] crc;
        int         lat;
        int         start_cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic done_prev = 1'b0;

    crc_serial dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .crc_out   (crc_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("crc_at_done", {24'd0, crc_out}, {24'd0, e.crc});
                chk("done_latency", cyc - e.start_cyc, e.lat);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
        done_prev <= (rst === 1'b0) ? done : 1'b0;
    end

    // Drives one frame from the current negedge. Gaps of gap_len idle cycles follow
    // bits 2 and 5, where crc_out must hold g2/g5. mid>0 pulses start alongside that bit.
    task automatic frame(input logic [7:0] data, input logic [7:0] exp_crc, input int gap_len,
                         input logic [7:0] g2, input logic [7:0] g5, input int mid);
        exp_t e;
        e.crc       = exp_crc;
        e.lat       = 9 + 2 * gap_len;
        e.start_cyc = cyc;
        q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_shift", {30'd0, busy, ready}, 32'd3);
        for (int i = 7; i >= 0; i--) begin
            bit_in    = data[i];
            bit_valid = 1'b1;
            start     = (mid == 8 - i);
            @(negedge clk);
            start     = 1'b0;
            bit_valid = 1'b0;
            if (gap_len > 0 && (i == 6 || i == 3)) begin
                for (int g = 0; g < gap_len; g++) begin
                    bit_in = ~bit_in;
                    chk("crc_hold_in_gap", {24'd0, crc_out}, {24'd0, (i == 6) ? g2 : g5});
                    chk("no_early_done", {31'd0, done}, 32'd0);
                    @(negedge clk);
                end
            end
            if (i > 0) chk("no_done_mid_frame", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        // Reset holds everything at zero even while start/bit_valid toggle
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk("rst_outputs", {21'd0, ready, busy, done, crc_out}, 32'd0);
            start = ~start; bit_valid = ~bit_valid;
        end
        rst = 1'b0; start = 1'b0; bit_valid = 1'b1;
        @(negedge clk);
        chk("idle_ignores_valid", {21'd0, ready, busy, done, crc_out}, 32'd0);
        bit_valid = 1'b0;

        frame(8'h01, 8'h07, 0, 8'h00, 8'h00, 0);
        drain();
        @(negedge clk);
        chk("crc_hold_in_done", {24'd0, crc_out}, 32'h07);
        chk("done_cleared", {31'd0, done}, 32'd0);

        frame(8'hFF, 8'hF3, 3, 8'h09, 8'h5D, 0);
        drain();

        frame(8'h00, 8'h00, 0, 8'h00, 8'h00, 4);
        drain();

        // Back-to-back: second start lands in the first frame's done cycle
        frame(8'h01, 8'h07, 0, 8'h00, 8'h00, 0);
        frame(8'hFF, 8'hF3, 0, 8'h00, 8'h00, 0);
        drain();

        // Abort mid-frame with reset; partial CRC is discarded
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            @(negedge clk);
        end
        chk("partial_crc", {24'd0, crc_out}, 32'h2D);
        bit_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {21'd0, ready, busy, done, crc_out}, 32'd0);
        frame(8'h01, 8'h07, 0, 8'h00, 8'h00, 0);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
